// File: rtl/mmc_round_scheduler.sv
// mmc_round_scheduler: round-robin arbiter, round sequencer and scorekeeper for the shared counter.
// Optional RUN timeout enabled by defining MMC_SCHED_TIMEOUT_EN.
module mmc_round_scheduler #(
    parameter int ROUND_LIMIT = 15,
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] req_mode0,
    input  logic [1:0] req_mode1,
    input  logic [3:0] req_init0,
    input  logic [3:0] req_init1,
    input  logic       new_game,
    input  logic [3:0] count,
    output logic [1:0] grant,
    output logic [1:0] ctrlBus,
    output logic [3:0] initValue,
    output logic       INIT,
    output logic       round_done,
    output logic       round_abort,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic       GAMEOVER,
    output logic [1:0] WHO,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, SCORE, OVER} state_t;
    localparam logic [3:0] LIMIT = 4'(ROUND_LIMIT);
    state_t state, state_nx;
    logic last, owner, pick, terminal, inc_p, win, abort, expire;
    logic [4:0] step;
    logic [3:0] inc_score, new_score;
    assign owner = grant[1];
    // 1 selects player 1: a lone request wins, a tie goes to whoever was not served last
    assign pick = ~req[0] | (req[1] & ~last);
    assign step = ctrlBus[0] ? 5'd2 : 5'd1;
    assign terminal = ctrlBus[1] ? ({1'b0, count} < step) : ({1'b0, count} >= 5'd16 - step);
    assign inc_p = ctrlBus[1] ? ~owner : owner;
    assign inc_score = inc_p ? score1 : score0;
    assign new_score = (inc_score == 4'hF) ? 4'hF : inc_score + 4'd1;
    assign win = !abort && new_score == LIMIT;
`ifdef MMC_SCHED_TIMEOUT_EN
    localparam logic [7:0] TMO = 8'(TIMEOUT - 1);
    logic [7:0] run_cnt;
    assign expire = run_cnt == TMO;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt <= '0;
            abort <= 1'b0;
        end else begin
            run_cnt <= (state == RUN) ? run_cnt + 8'd1 : 8'd0;
            if (state == RUN) abort <= !terminal;
        end
    end
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
    assign expire = 1'b0;
    assign abort = 1'b0;
`endif
    always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req ? LOAD : IDLE;
            LOAD:    state_nx = RUN;
            RUN:     state_nx = (terminal || expire) ? SCORE : RUN;
            SCORE:   state_nx = win ? OVER : IDLE;
            OVER:    state_nx = new_game ? IDLE : OVER;
            default: state_nx = IDLE;
        endcase
    end
    assign INIT = state == LOAD;
    assign busy = state == LOAD || state == RUN || state == SCORE;
    assign round_done = state == SCORE && !abort;
    assign round_abort = state == SCORE && abort;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant <= 2'b00;
            ctrlBus <= 2'b00;
            initValue <= 4'd0;
            last <= 1'b1;
            score0 <= 4'd0;
            score1 <= 4'd0;
            GAMEOVER <= 1'b0;
            WHO <= 2'b00;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    grant <= pick ? 2'b10 : 2'b01;
                    ctrlBus <= pick ? req_mode1 : req_mode0;
                    initValue <= pick ? req_init1 : req_init0;
                end
                SCORE: begin
                    last <= owner;
                    grant <= 2'b00;
                    if (!abort) begin
                        if (inc_p) score1 <= new_score;
                        else score0 <= new_score;
                        if (win) begin
                            GAMEOVER <= 1'b1;
                            WHO <= inc_p ? 2'b10 : 2'b01;
                        end
                    end
                end
                OVER: if (new_game) begin
                    score0 <= 4'd0;
                    score1 <= 4'd0;
                    GAMEOVER <= 1'b0;
                    WHO <= 2'b00;
                    last <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mmc_round_scheduler.sv
// tb_mmc_round_scheduler: directed rounds against a round-level timeline model plus literal checks.
// Define MMC_SCHED_TIMEOUT_EN for both files to exercise the timeout path.
module tb_mmc_round_scheduler;
    localparam int LIMIT = 3;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] req = 2'b00, req_mode0 = 2'b00, req_mode1 = 2'b00;
    logic [3:0] req_init0 = 4'd0, req_init1 = 4'd0, count;
    logic new_game = 1'b0;
    logic [1:0] grant, ctrlBus, WHO;
    logic [3:0] initValue, score0, score1;
    logic INIT, round_done, round_abort, GAMEOVER, busy;
    int checks = 0;
    int errors = 0;
    logic hold_count = 1'b0;

    always #5 clk = ~clk;

    mmc_round_scheduler #(.ROUND_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_mode0(req_mode0), .req_mode1(req_mode1),
        .req_init0(req_init0), .req_init1(req_init1), .new_game(new_game), .count(count),
        .grant(grant), .ctrlBus(ctrlBus), .initValue(initValue), .INIT(INIT),
        .round_done(round_done), .round_abort(round_abort), .score0(score0), .score1(score1),
        .GAMEOVER(GAMEOVER), .WHO(WHO), .busy(busy)
    );

    // Counter stand-in: loads on INIT, otherwise steps by the driven mode; optionally stuck at 7
    logic [3:0] cnt = 4'd0;
    assign count = cnt;
    always @(posedge clk)
        if (hold_count) cnt <= 4'd7;
        else if (INIT) cnt <= initValue;
        else cnt <= ctrlBus[1] ? cnt - (ctrlBus[0] ? 4'd2 : 4'd1) : cnt + (ctrlBus[0] ? 4'd2 : 4'd1);

    typedef struct packed {
        logic [1:0] grant;
        logic [1:0] ctrl;
        logic [3:0] init_v;
        logic       init_p;
        logic       done;
        logic       abort;
        logic [3:0] s0;
        logic [3:0] s1;
        logic       go;
        logic [1:0] who;
        logic       busy;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    exp_t act;
    bit valid = 0;
    int m_s[2];
    int m_last;
    bit m_over;
    logic [1:0] m_who, m_ctrl;
    logic [3:0] m_init;

    assign act = {grant, ctrlBus, initValue, INIT, round_done, round_abort, score0, score1, GAMEOVER, WHO, busy};

    function automatic exp_t idle_e();
        return '{2'b00, m_ctrl, m_init, 1'b0, 1'b0, 1'b0, 4'(m_s[0]), 4'(m_s[1]), m_over, m_who, 1'b0};
    endfunction

    // Lay out a whole round's cycle-by-cycle outputs at the moment it is granted
    task automatic start_round();
        int p, s, v, runs, w;
        logic [1:0] md;
        logic [3:0] iv;
        bit ab;
        exp_t e;
        p = (req == 2'b11) ? 1 - m_last : int'(req[1]);
        md = p ? req_mode1 : req_mode0;
        iv = p ? req_init1 : req_init0;
        s = md[0] ? 2 : 1;
        v = iv;
        if (!md[1]) runs = (v >= 16 - s) ? 1 : (16 - s - v + s - 1) / s + 1;
        else runs = v / s + 1;
        ab = 0;
`ifdef MMC_SCHED_TIMEOUT_EN
        if (runs > TMO) begin
            runs = TMO;
            ab = 1;
        end
`endif
        m_ctrl = md;
        m_init = iv;
        e = '{p ? 2'b10 : 2'b01, md, iv, 1'b1, 1'b0, 1'b0, 4'(m_s[0]), 4'(m_s[1]), 1'b0, 2'b00, 1'b1};
        q.push_back(e);
        e.init_p = 1'b0;
        repeat (runs) q.push_back(e);
        e.done = !ab;
        e.abort = ab;
        q.push_back(e);
        if (!ab) begin
            w = md[1] ? 1 - p : p;
            if (m_s[w] < 15) m_s[w]++;
            if (m_s[w] == LIMIT) begin
                m_over = 1;
                m_who = w ? 2'b10 : 2'b01;
            end
        end
        m_last = p;
        q.push_back(idle_e());
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_s[0] = 0;
            m_s[1] = 0;
            m_last = 1;
            m_over = 0;
            m_who = 2'b00;
            m_ctrl = 2'b00;
            m_init = 4'd0;
            valid = 1;
            cur = idle_e();
        end else begin
            if (q.size() == 0) begin
                if (m_over && new_game) begin
                    m_s[0] = 0;
                    m_s[1] = 0;
                    m_over = 0;
                    m_who = 2'b00;
                    m_last = 1;
                end else if (!m_over && req != 2'b00) start_round();
            end
            cur = (q.size() != 0) ? q.pop_front() : idle_e();
        end
    end

    always @(negedge clk)
        if (valid) begin
            checks++;
            if (act !== cur) begin
                errors++;
                $display("FAIL outputs @%0t: got %h expected %h", $time, act, cur);
            end
        end

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // From the LOAD-cycle negedge: record RUN counts, stop at SCORE, step into the following cycle
    task automatic finish_round(output int n, output logic [15:0] seen, output logic [1:0] da);
        n = 0;
        seen = '0;
        repeat (40) begin
            @(negedge clk);
            if (round_done || round_abort) break;
            n++;
            seen = {seen[11:0], count};
        end
        da = {round_done, round_abort};
        check("round_end", 32'(round_done | round_abort), 32'd1);
        @(negedge clk);
    endtask

    task automatic play(input logic [1:0] r, input logic [1:0] md, input logic [3:0] iv, input bit hold,
                        output logic [1:0] g, output int n, output logic [15:0] seen, output logic [1:0] da);
        if (r[0]) begin
            req_mode0 = md;
            req_init0 = iv;
        end
        if (r[1]) begin
            req_mode1 = md;
            req_init1 = iv;
        end
        req = r;
        @(negedge clk);
        g = grant;
        check("load_init", {INIT, initValue}, {1'b1, iv});
        if (!hold) req = 2'b00;
        finish_round(n, seen, da);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [1:0] g, da;
        logic [7:0] grants;
        logic [15:0] seen;
        int n;
        req = 2'b11;
        req_init0 = 4'd12;
        repeat (2) @(negedge clk);
        check("reset_grant", grant, 2'b00);
        check("reset_busy_init", {busy, INIT, round_done, round_abort}, 4'b0000);
        check("reset_scores", {score1, score0}, 8'h00);
        check("reset_game", {GAMEOVER, WHO, ctrlBus, initValue}, 9'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_grant", grant, 2'b01);
        check("first_load", {INIT, initValue}, {1'b1, 4'd12});
        req = 2'b00;
        finish_round(n, seen, da);
        check("up_seq", seen, 16'hCDEF);
        check("up_runs", n, 4);
        check("up_score", {score1, score0}, 8'h01);

        play(2'b10, 2'b11, 4'd5, 0, g, n, seen, da);
        check("down_seq", seen, 16'h0531);
        check("down_score", {score1, score0}, 8'h02);
        play(2'b10, 2'b01, 4'd14, 0, g, n, seen, da);
        check("instant_runs", n, 1);
        check("instant_score", {score1, score0}, 8'h12);

        do_reset();
        new_game = 1'b1;
        grants = '0;
        repeat (4) begin
            play(2'b11, 2'b00, 4'd14, 1, g, n, seen, da);
            grants = {grants[5:0], g};
        end
        req = 2'b00;
        new_game = 1'b0;
        check("arb_grants", grants, 8'h66);
        check("arb_scores", {score1, score0}, 8'h22);

        do_reset();
        repeat (3) play(2'b10, 2'b00, 4'd14, 0, g, n, seen, da);
        check("over_flags", {GAMEOVER, WHO}, 3'b110);
        check("over_scores", {score1, score0}, 8'h30);
        req = 2'b11;
        repeat (3) begin
            @(negedge clk);
            check("over_req_ignored", {grant, busy}, 3'b000);
        end
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check("new_game_clear", {GAMEOVER, WHO, score1, score0}, 11'd0);
        play(2'b11, 2'b00, 4'd14, 0, g, n, seen, da);
        check("new_game_tie_grant", g, 2'b01);

`ifdef MMC_SCHED_TIMEOUT_EN
        hold_count = 1'b1;
        play(2'b01, 2'b00, 4'd7, 0, g, n, seen, da);
        hold_count = 1'b0;
        check("timeout_runs", n, TMO);
        check("timeout_flags", da, 2'b01);
        check("timeout_scores", {score1, score0}, 8'h01);
`endif

        req_mode0 = 2'b00;
        req_init0 = 4'd12;
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_round", {grant, INIT, busy, round_done, score1, score0}, 13'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
